switch_box_config_loader: RTL and testbench

SWITCH_BOX_CONFIG_LOADER -- requirements
Module: switch_box_config_loader

---
 rtl/switch_box_config_loader_if.sv | 12 +
 rtl/switch_box_config_loader.sv | 115 +++++++++++
 tb/tb_switch_box_config_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/switch_box_config_loader_if.sv
// Configuration beat channel into the switch-box config loader.
interface switch_box_config_loader_if #(
    parameter int DW = 8
) ();
    logic          cfg_start;
    logic          cfg_valid;
    logic [DW-1:0] cfg_data;
    logic          cfg_ready;

    modport master (output cfg_start, output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_start, input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/switch_box_config_loader.sv
// Streams DW-bit beats into a shadow register and commits them atomically to switch-box config c.
// Define CFG_CHECK_EN to require a trailing XOR checksum beat before commit.
module switch_box_config_loader #(
    parameter  int WS     = 7,
    parameter  int WD     = 6,
    parameter  int DW     = 8,
    localparam int CW     = WS*6 + WD/2*6,
    localparam int NBEATS = (CW + DW - 1) / DW,
    localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    switch_box_config_loader_if.slave cfg,
    output logic [CW-1:0]             c,
    output logic                      cfg_busy,
    output logic                      cfg_done,
    output logic                      cfg_err
);
`ifdef CFG_CHECK_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif

    state_t         state, state_nx;
    logic [BCW-1:0] beat_cnt;
    logic [CW-1:0]  shadow;
    logic           ready, accept, restart, last_beat;

`ifdef CFG_CHECK_EN
    assign ready = (state == LOAD) || (state == CHECK);
`else
    assign ready = (state == LOAD);
`endif
    assign accept    = cfg.cfg_valid && ready;
    // A start during COMMIT is ignored so the switch box always gets a complete config.
    assign restart   = cfg.cfg_start && (state != COMMIT);
    assign last_beat = (beat_cnt == BCW'(NBEATS-1));
    assign cfg.cfg_ready = ready;
    assign cfg_busy  = (state != IDLE);

`ifdef CFG_CHECK_EN
    logic [DW-1:0] csum;
    logic          csum_ok;
    logic          err_q;

    assign csum_ok = (cfg.cfg_data == csum);
    assign cfg_err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (restart) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (accept && state == LOAD) begin
            csum <= csum ^ cfg.cfg_data;
        end else if (accept && state == CHECK && !csum_ok) begin
            err_q <= 1'b1;
        end
    end
`else
    assign cfg_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (restart) begin
            state_nx = LOAD;
        end else begin
            case (state)
                LOAD: if (accept && last_beat) begin
`ifdef CFG_CHECK_EN
                    state_nx = CHECK;
`else
                    state_nx = COMMIT;
`endif
                end
`ifdef CFG_CHECK_EN
                CHECK: if (accept) state_nx = csum_ok ? COMMIT : IDLE;
`endif
                COMMIT:  state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end

    // Shadow is sized to CW; bits of the last beat beyond CW have no home and fall away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c        <= '0;
            beat_cnt <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (restart) begin
                beat_cnt <= '0;
            end else if (accept && state == LOAD) begin
                for (int i = 0; i < CW; i++)
                    if (i / DW == int'(beat_cnt)) shadow[i] <= cfg.cfg_data[i % DW];
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (state == COMMIT) begin
                c        <= shadow;
                cfg_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_switch_box_config_loader.sv
// Directed table-driven bench for switch_box_config_loader (WS=7, WD=6, DW=8 -> CW=60, 8 beats).
module tb_switch_box_config_loader;
    localparam int DW = 8;
    localparam int CW = 60;
`ifdef CFG_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [CW-1:0] C1 = 60'h807060504030201;
    localparam logic [CW-1:0] CF = 60'hFFFFFFFFFFFFFFF;
    localparam logic [CW-1:0] CA = 60'h8A7A6A5A4A3A2A1;

    typedef struct {
        logic          rst_n;
        logic          start;
        logic          valid;
        logic [DW-1:0] data;
        logic [CW-1:0] c;
        logic          busy;
        logic          ready;
        logic          done;
        logic          err;
    } vec_t;

    vec_t vecs[$];
    logic clk = 1'b0;
    logic rst_n;
    logic [CW-1:0] c;
    logic cfg_busy, cfg_done, cfg_err;
    int checks = 0;
    int errors = 0;

    switch_box_config_loader_if #(.DW(DW)) cfg ();

    switch_box_config_loader #(.WS(7), .WD(6), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg      (cfg),
        .c        (c),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic push(input logic r, input logic s, input logic v, input logic [DW-1:0] d,
                        input logic [CW-1:0] ec, input logic eb, input logic er,
                        input logic ed, input logic ee);
        vec_t t;
        t.rst_n = r; t.start = s; t.valid = v; t.data = d;
        t.c = ec; t.busy = eb; t.ready = er; t.done = ed; t.err = ee;
        vecs.push_back(t);
    endtask

    // Full load: start, 8 data beats (optional idle gaps), optional checksum, commit, one quiet cycle.
    task automatic push_load(input logic [DW-1:0] d0, input logic [DW-1:0] step,
                             input logic [DW-1:0] csum, input logic [CW-1:0] cprev,
                             input logic [CW-1:0] cnew, input bit gaps, input bit sv);
        push(1, 1, sv, 8'h55, cprev, 1, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            if (gaps) push(1, 0, 0, 8'h00, cprev, 1, 1, 0, 0);
            push(1, 0, 1, d0 + 8'(k) * step, cprev, 1, (k < 7) || CHK, 0, 0);
        end
        if (CHK) push(1, 0, 1, csum, cprev, 1, 0, 0, 0);
        push(1, 0, 0, 8'h00, cnew, 0, 0, 1, 0);
        push(1, 0, 0, 8'h00, cnew, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int idx, input logic [CW-1:0] got,
                       input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
        rst_n = r; cfg.cfg_start = s; cfg.cfg_valid = v; cfg.cfg_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t t, input int idx);
        drive(t.rst_n, t.start, t.valid, t.data);
        chk("c", idx, c, t.c);
        chk("busy", idx, CW'(cfg_busy), CW'(t.busy));
        chk("ready", idx, CW'(cfg.cfg_ready), CW'(t.ready));
        chk("done", idx, CW'(cfg_done), CW'(t.done));
        chk("err", idx, CW'(cfg_err), CW'(t.err));
    endtask

    initial begin
        rst_n = 1'b0; cfg.cfg_start = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_data = '0;

        // reset state, valid ignored under reset
        push(0, 0, 0, 8'h00, '0, 0, 0, 0, 0);
        push(0, 0, 1, 8'hAA, '0, 0, 0, 0, 0);
        // back-to-back 0x01..0x08
        push_load(8'h01, 8'h01, 8'h08, '0, C1, 0, 0);
        // reset for 2 cycles after 4 beats; later valid beats are ignored
        push(1, 1, 0, 8'h00, C1, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) push(1, 0, 1, 8'h55, C1, 1, 1, 0, 0);
        push(0, 0, 1, 8'h55, '0, 0, 0, 0, 0);
        push(0, 0, 1, 8'h55, '0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) push(1, 0, 1, 8'h66, '0, 0, 0, 0, 0);
        // same data with a gap every other cycle; c holds 0 until commit
        push_load(8'h01, 8'h01, 8'h08, '0, C1, 1, 0);
        // 3 beats of 0x55, then restart (with a colliding beat that must drop), then 8x 0xFF
        push(1, 1, 0, 8'h00, C1, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) push(1, 0, 1, 8'h55, C1, 1, 1, 0, 0);
        push_load(8'hFF, 8'h00, 8'h00, C1, CF, 0, 1);
`ifdef CFG_CHECK_EN
        // good checksum commits
        push_load(8'h01, 8'h01, 8'h08, CF, C1, 0, 0);
        // bad checksum: err sticks, c unchanged, no done
        push(1, 1, 0, 8'h00, C1, 1, 1, 0, 0);
        for (int k = 0; k < 8; k++) push(1, 0, 1, 8'h21 + 8'(k), C1, 1, 1, 0, 0);
        push(1, 0, 1, 8'h00, C1, 0, 0, 0, 1);
        push(1, 0, 0, 8'h00, C1, 0, 0, 0, 1);
        push(1, 0, 0, 8'h00, C1, 0, 0, 0, 1);
        push(1, 1, 0, 8'h00, C1, 1, 1, 0, 0);
`endif
        push(0, 0, 0, 8'h00, '0, 0, 0, 0, 0);

        foreach (vecs[i]) apply(vecs[i], i);

        // start held high across COMMIT: commit finishes, then a new LOAD begins
        drive(1, 1, 0, 8'h00);
        for (int k = 0; k < 8; k++) drive(1, 0, 1, 8'hA1 + 8'(k));
        if (CHK) drive(1, 0, 1, 8'h08);
        chk("commit_busy", 1000, CW'(cfg_busy), CW'(1'b1));
        chk("commit_ready", 1000, CW'(cfg.cfg_ready), CW'(1'b0));
        drive(1, 1, 0, 8'h00);
        chk("hold_c", 1001, c, CA);
        chk("hold_done", 1001, CW'(cfg_done), CW'(1'b1));
        chk("hold_busy", 1001, CW'(cfg_busy), CW'(1'b0));
        drive(1, 1, 0, 8'h00);
        chk("relaunch_busy", 1002, CW'(cfg_busy), CW'(1'b1));
        chk("relaunch_ready", 1002, CW'(cfg.cfg_ready), CW'(1'b1));
        chk("relaunch_done", 1002, CW'(cfg_done), CW'(1'b0));
        chk("relaunch_c", 1002, c, CA);
        drive(1, 0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
